// File: rtl/program_stream_writer.sv
// program_stream_writer: turns instruction words into the loader's framed
// ASCII stream: a "{" line, one lowercase hex line per word, a "}" line.
module program_stream_writer #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              word_valid,
   input  logic [DATA_W-1:0] word_data,
   input  logic              word_last,
   output logic              word_ready,
   output logic              byte_valid,
   output logic [7:0]        byte_data,
   input  logic              byte_ready,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  line_count
);
   localparam int NIB   = DATA_W / 4;
   localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_OPEN_BR,
      S_OPEN_NL,
      S_WAIT,
      S_HEX,
      S_LINE_NL,
      S_CLOSE_BR,
      S_CLOSE_NL
   } state_t;

   state_t            r_state, w_state;
   logic [DATA_W-1:0] r_shift, w_shift;
   logic [NIB_W-1:0]  r_nib, w_nib;
   logic              r_last, w_last;
   logic [CNT_W-1:0]  r_cnt, w_cnt;
   logic              r_bvalid, w_bvalid;
   logic [7:0]        r_bdata, w_bdata;
   logic              r_busy, w_busy;
   logic              r_done, w_done;
   logic              w_xfer;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   always_comb begin
      w_xfer  = r_bvalid && byte_ready;
      w_state = r_state;
      w_shift = r_shift;
      w_nib   = r_nib;
      w_last  = r_last;
      w_cnt   = r_cnt;
      w_busy  = r_busy;
      w_done  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state = S_OPEN_BR;
               w_cnt   = '0;
               w_busy  = 1'b1;
            end
         end
         S_OPEN_BR: if (w_xfer) w_state = S_OPEN_NL;
         S_OPEN_NL: if (w_xfer) w_state = S_WAIT;
         S_WAIT: begin
            if (word_valid) begin
               w_state = S_HEX;
               w_shift = word_data;
               w_last  = word_last;
               w_nib   = '0;
               if (r_cnt != '1) w_cnt = r_cnt + CNT_W'(1);
            end
         end
         S_HEX: begin
            if (w_xfer) begin
               w_shift = r_shift << 4;
               w_nib   = r_nib + NIB_W'(1);
               if (r_nib == NIB_W'(NIB - 1)) w_state = S_LINE_NL;
            end
         end
         S_LINE_NL: if (w_xfer) w_state = r_last ? S_CLOSE_BR : S_WAIT;
         S_CLOSE_BR: if (w_xfer) w_state = S_CLOSE_NL;
         S_CLOSE_NL: begin
            if (w_xfer) begin
               w_state = S_IDLE;
               w_busy  = 1'b0;
               w_done  = 1'b1;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   // Byte outputs are registered from the state being entered
   always_comb begin
      w_bvalid = 1'b1;
      w_bdata  = r_bdata;
      unique case (w_state)
         S_OPEN_BR:                        w_bdata = 8'h7B;
         S_OPEN_NL, S_LINE_NL, S_CLOSE_NL: w_bdata = 8'h0A;
         S_HEX:      w_bdata = hex_char(w_shift[DATA_W-1 -: 4]);
         S_CLOSE_BR:                       w_bdata = 8'h7D;
         default:                          w_bvalid = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_nib    <= '0;
         r_last   <= 1'b0;
         r_cnt    <= '0;
         r_bvalid <= 1'b0;
         r_bdata  <= 8'h00;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_shift  <= w_shift;
         r_nib    <= w_nib;
         r_last   <= w_last;
         r_cnt    <= w_cnt;
         r_bvalid <= w_bvalid;
         r_bdata  <= w_bdata;
         r_busy   <= w_busy;
         r_done   <= w_done;
      end
   end

   assign word_ready = (r_state == S_WAIT);
   assign byte_valid = r_bvalid;
   assign byte_data  = r_bdata;
   assign busy       = r_busy;
   assign done       = r_done;
   assign line_count = r_cnt;

endmodule
